// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
//   Miss-handling initiator for the memory4c model. On a cache miss it issues
//   one read per cycle for every 16-bit word of the block, back to back,
//   steers each returning word into the cache data array with its word index,
//   and pulses the tag-array write when the last word lands.
//
// Ports
//   clk              in   system clock, rising edge
//   rst              in   synchronous, active-high reset
//   miss_detected    in   cache miss this cycle
//   miss_address     in   byte address that missed
//   fsm_busy         out  cache must stall
//   mem_enable       out  memory4c enable
//   mem_wr           out  memory4c wr (always 0, reads only)
//   mem_addr         out  memory4c byte address
//   mem_data_out     in   memory4c read data
//   mem_data_valid   in   memory4c read data valid
//   write_data_array out  write strobe for one cache data word
//   data_word_index  out  word slot being written
//   data_word        out  word to write
//   write_tag_array  out  one-cycle pulse, block complete
// -----------------------------------------------------------------------------
module cache_fill_fsm #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_WIDTH-1:0]              miss_address,
  output logic                               fsm_busy,
  output logic                               mem_enable,
  output logic                               mem_wr,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  input  logic [15:0]                        mem_data_out,
  input  logic                               mem_data_valid,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] data_word_index,
  output logic [15:0]                        data_word,
  output logic                               write_tag_array
);

  localparam int IDXW = $clog2(WORDS_PER_BLOCK);
  localparam int CNTW = IDXW + 1;
  // Byte-offset bits within a block: word index bits plus the byte-in-word bit.
  localparam int OFFW = IDXW + 1;

  localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = {ADDR_WIDTH{1'b1}} << OFFW;
  localparam logic [CNTW-1:0]       CNT_FULL  = CNTW'(WORDS_PER_BLOCK);
  localparam logic [CNTW-1:0]       CNT_LAST  = CNTW'(WORDS_PER_BLOCK - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  // MEM_LATENCY is informational (responses are counted, not cycles); it is
  // only sanity-checked here together with the block-size constraint.
  if (MEM_LATENCY < 1 || WORDS_PER_BLOCK < 2 ||
      (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_param_check
    $error("cache_fill_fsm: invalid parameter set");
  end

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_base_addr;
  logic [CNTW-1:0]       r_issue_cnt;
  logic [CNTW-1:0]       r_recv_cnt;

  logic                  w_issue_en;
  logic [ADDR_WIDTH-1:0] w_word_off;

  // issue_cnt stops at WORDS_PER_BLOCK, which caps enables per fill.
  assign w_issue_en = (r_issue_cnt < CNT_FULL);
  // base_addr has its block-offset bits cleared, so OR-ing in the word offset
  // is a carry-free add that can never leave the block (0xFFF0 -> 0xFFFE).
  assign w_word_off = ADDR_WIDTH'({r_issue_cnt[IDXW-1:0], 1'b0});
  assign mem_wr     = 1'b0;

  always_comb begin
    fsm_busy         = 1'b0;
    mem_enable       = 1'b0;
    mem_addr         = '0;
    write_data_array = 1'b0;
    data_word_index  = '0;
    data_word        = '0;
    write_tag_array  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Stall in the miss cycle itself.
        fsm_busy = miss_detected;
      end
      S_FILL: begin
        fsm_busy         = 1'b1;
        mem_enable       = w_issue_en;
        if (w_issue_en) begin
          mem_addr = r_base_addr | w_word_off;
        end
        write_data_array = mem_data_valid;
        data_word        = mem_data_out;
        data_word_index  = r_recv_cnt[IDXW-1:0];
        write_tag_array  = mem_data_valid && (r_recv_cnt == CNT_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base_addr <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (miss_detected) begin
            r_base_addr <= miss_address & BLK_MASK;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_issue_en) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
          end
          if (mem_data_valid) begin
            r_recv_cnt <= r_recv_cnt + 1'b1;
          end
          if (write_tag_array) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
